// File: rtl/uart_dbg_cmd.sv
// uart_dbg_cmd: debug command engine on the client side of the UART FIFOs.
// Define UART_DBG_ECHO_EN to echo each raw command word ahead of its response.
module uart_dbg_cmd #(
  parameter int DBIT    = 32,
  parameter int TIMEOUT = 1024,
  parameter int TO_BIT  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd_uart,
  input  logic            tx_full,
  output logic            wr_uart,
  output logic [DBIT-1:0] w_data,
  output logic            cpu_run,
  output logic            cpu_step,
  input  logic            cpu_halted,
  output logic            dbg_rd_req,
  output logic            dbg_sel,
  output logic [15:0]     dbg_addr,
  input  logic [DBIT-1:0] dbg_rd_data,
  input  logic            dbg_rd_valid,
  output logic            busy
);

  localparam logic [7:0] OP_RUN   = 8'h01;
  localparam logic [7:0] OP_STEP  = 8'h02;
  localparam logic [7:0] OP_HALT  = 8'h03;
  localparam logic [7:0] OP_RDREG = 8'h10;
  localparam logic [7:0] OP_RDMEM = 8'h11;

  localparam logic [TO_BIT-1:0] TO_LAST = TO_BIT'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    REQ,
    WAIT,
    SEND
`ifdef UART_DBG_ECHO_EN
    ,ECHO
`endif
  } state_e;

  state_e state_q, state_d;

  logic [DBIT-1:0]   cmd_q, cmd_d;
  logic [DBIT-1:0]   resp_q, resp_d;
  logic [TO_BIT-1:0] cnt_q, cnt_d;
  logic              rd_uart_q, rd_uart_d;
  logic              wr_uart_q, wr_uart_d;
  logic [DBIT-1:0]   w_data_q, w_data_d;
  logic              run_q, run_d;
  logic              step_q, step_d;
  logic              req_q, req_d;
  logic              sel_q, sel_d;
  logic [15:0]       addr_q, addr_d;
  logic              halted_q;
  logic              busy_q;

  logic [7:0]  op;
  logic [15:0] arg;
  logic        is_run;
  logic        is_step;
  logic        is_halt;
  logic        is_rdreg;
  logic        is_rdmem;
  logic        is_rd;
  logic        halt_rise;
  logic        unused_bits;

  assign op        = cmd_q[31:24];
  assign arg       = cmd_q[15:0];
  assign is_run    = (op == OP_RUN);
  assign is_step   = (op == OP_STEP);
  assign is_halt   = (op == OP_HALT);
  assign is_rdreg  = (op == OP_RDREG);
  assign is_rdmem  = (op == OP_RDMEM);
  assign is_rd     = is_rdreg | is_rdmem;
  assign halt_rise = cpu_halted & ~halted_q;

  assign unused_bits = ^cmd_q[23:16];

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    resp_d    = resp_q;
    cnt_d     = cnt_q;
    rd_uart_d = 1'b0;
    wr_uart_d = 1'b0;
    w_data_d  = w_data_q;
    run_d     = run_q;
    step_d    = 1'b0;
    req_d     = 1'b0;
    sel_d     = sel_q;
    addr_d    = addr_q;

    // A RUN decoded below overrides a simultaneous halt edge.
    if (halt_rise) run_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_empty) begin
          cmd_d     = r_data;
          rd_uart_d = 1'b1;
          state_d   = DECODE;
        end
      end
      DECODE: begin
        unique case (1'b1)
          is_run: begin
            run_d  = 1'b1;
            resp_d = {8'hAC, 16'h0000, op};
          end
          is_step: begin
            if (run_q) begin
              resp_d = {8'hEE, 16'h0001, OP_STEP};
            end else begin
              step_d = 1'b1;
              resp_d = {8'hAC, 16'h0000, op};
            end
          end
          is_halt: begin
            run_d  = 1'b0;
            resp_d = {8'hAC, 16'h0000, op};
          end
          is_rd: begin
            sel_d  = is_rdmem;
            addr_d = is_rdmem ? arg : {11'b0, arg[4:0]};
          end
          default: begin
            resp_d = {8'hEE, 16'h0000, op};
          end
        endcase
`ifdef UART_DBG_ECHO_EN
        state_d = ECHO;
`else
        req_d   = is_rd;
        state_d = is_rd ? REQ : SEND;
`endif
      end
`ifdef UART_DBG_ECHO_EN
      ECHO: begin
        if (!tx_full) begin
          wr_uart_d = 1'b1;
          w_data_d  = cmd_q;
          req_d     = is_rd;
          state_d   = is_rd ? REQ : SEND;
        end
      end
`endif
      REQ: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (dbg_rd_valid) begin
          resp_d  = dbg_rd_data;
          state_d = SEND;
        end else if (cnt_q == TO_LAST) begin
          resp_d  = {8'hEE, 8'hFF, 8'h00, op};
          state_d = SEND;
        end else begin
          cnt_d = cnt_q + TO_BIT'(1);
        end
      end
      SEND: begin
        if (!tx_full) begin
          wr_uart_d = 1'b1;
          w_data_d  = resp_q;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      resp_q    <= '0;
      cnt_q     <= '0;
      rd_uart_q <= 1'b0;
      wr_uart_q <= 1'b0;
      w_data_q  <= '0;
      run_q     <= 1'b0;
      step_q    <= 1'b0;
      req_q     <= 1'b0;
      sel_q     <= 1'b0;
      addr_q    <= '0;
      halted_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      resp_q    <= resp_d;
      cnt_q     <= cnt_d;
      rd_uart_q <= rd_uart_d;
      wr_uart_q <= wr_uart_d;
      w_data_q  <= w_data_d;
      run_q     <= run_d;
      step_q    <= step_d;
      req_q     <= req_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      halted_q  <= cpu_halted;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign rd_uart    = rd_uart_q;
  assign wr_uart    = wr_uart_q;
  assign w_data     = w_data_q;
  assign cpu_run    = run_q;
  assign cpu_step   = step_q;
  assign dbg_rd_req = req_q;
  assign dbg_sel    = sel_q;
  assign dbg_addr   = addr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_dbg_cmd.sv
// tb_uart_dbg_cmd: directed table plus corner sequences for uart_dbg_cmd.
// FIFOs and the debug read port are modelled on the falling clock edge.
module tb_uart_dbg_cmd;

`ifdef UART_DBG_ECHO_EN
  localparam int NW = 2;
`else
  localparam int NW = 1;
`endif
  localparam int TMO = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_empty = 1'b1;
  logic [31:0] r_data = 32'h0;
  logic        rd_uart;
  logic        tx_full = 1'b0;
  logic        wr_uart;
  logic [31:0] w_data;
  logic        cpu_run;
  logic        cpu_step;
  logic        cpu_halted = 1'b0;
  logic        dbg_rd_req;
  logic        dbg_sel;
  logic [15:0] dbg_addr;
  logic [31:0] dbg_rd_data = 32'h0;
  logic        dbg_rd_valid = 1'b0;
  logic        busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] rxq[$];
  logic [31:0] txq[$];
  int          txc[$];
  int          rd_cnt = 0;
  int          step_cnt = 0;
  int          req_cnt = 0;
  int          req_cyc = 0;
  int          fall_cyc = 0;
  int          lat_cnt = 0;
  int          rsp_lat = 0;
  logic [31:0] rsp_data = 32'h0;

  typedef struct {
    logic [31:0] cmd;
    int          lat;
    logic [31:0] rdata;
    logic [31:0] exp;
    int          stp;
    logic        run;
    logic        rd;
    logic        sel;
    logic [15:0] addr;
  } vec_t;

  vec_t tbl[10];

  uart_dbg_cmd dut (
    .clk          (clk),
    .reset        (reset),
    .rx_empty     (rx_empty),
    .r_data       (r_data),
    .rd_uart      (rd_uart),
    .tx_full      (tx_full),
    .wr_uart      (wr_uart),
    .w_data       (w_data),
    .cpu_run      (cpu_run),
    .cpu_step     (cpu_step),
    .cpu_halted   (cpu_halted),
    .dbg_rd_req   (dbg_rd_req),
    .dbg_sel      (dbg_sel),
    .dbg_addr     (dbg_addr),
    .dbg_rd_data  (dbg_rd_data),
    .dbg_rd_valid (dbg_rd_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    dbg_rd_valid = 1'b0;
    if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        dbg_rd_valid = 1'b1;
        dbg_rd_data  = rsp_data;
      end
    end
    if (dbg_rd_req) begin
      req_cnt++;
      req_cyc = cyc;
      lat_cnt = rsp_lat;
    end
    if (rd_uart) begin
      rd_cnt++;
      if (rxq.size() > 0) void'(rxq.pop_front());
    end
    if (wr_uart) begin
      txq.push_back(w_data);
      txc.push_back(cyc);
    end
    if (cpu_step) step_cnt++;
    if (rx_empty && rxq.size() > 0) fall_cyc = cyc;
    rx_empty = (rxq.size() == 0);
    r_data   = (rxq.size() > 0) ? rxq[0] : 32'h0;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_tx(input int n);
    int k;
    k = 0;
    while (txq.size() < n && k < 3000) begin
      tick(1);
      k++;
    end
    total++;
    if (txq.size() < n) begin
      bad++;
      $display("FAIL wait_tx: got %0d words want %0d", txq.size(), n);
    end
  endtask

  initial begin
    int tx0, rd0, st0, rq0, dly, k;

    tbl[0] = '{32'h01000000, 0, 32'h0, 32'hAC000001, 0, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[1] = '{32'h02000000, 0, 32'h0, 32'hEE000102, 0, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[2] = '{32'h03000000, 0, 32'h0, 32'hAC000003, 0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[3] = '{32'h02000000, 0, 32'h0, 32'hAC000002, 1, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[4] = '{32'h10000005, 2, 32'h12345678, 32'h12345678, 0, 1'b0, 1'b1, 1'b0, 16'h0005};
    tbl[5] = '{32'h1100ABCD, 3, 32'hCAFEF00D, 32'hCAFEF00D, 0, 1'b0, 1'b1, 1'b1, 16'hABCD};
    tbl[6] = '{32'h100000FF, 1, 32'h0BADBEEF, 32'h0BADBEEF, 0, 1'b0, 1'b1, 1'b0, 16'h001F};
    tbl[7] = '{32'h7F000000, 0, 32'h0, 32'hEE00007F, 0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[8] = '{32'h1100ABCD, 0, 32'h0, 32'hEEFF0011, 0, 1'b0, 1'b1, 1'b1, 16'hABCD};
    tbl[9] = '{32'h11000010, 1024, 32'h600DF00D, 32'h600DF00D, 0, 1'b0, 1'b1, 1'b1, 16'h0010};

    tick(3);
    chk("rst_ctl", {25'b0, rd_uart, wr_uart, cpu_run, cpu_step,
                    dbg_rd_req, dbg_sel, busy}, 32'h0);
    chk("rst_wdata", w_data, 32'h0);
    chk("rst_addr", {16'h0, dbg_addr}, 32'h0);
    reset = 1'b1;
    tick(2);
    chk("idle_busy", {31'b0, busy}, 32'h0);

    for (int i = 0; i < 10; i++) begin
      rsp_lat  = tbl[i].lat;
      rsp_data = tbl[i].rdata;
      tx0 = txq.size();
      rd0 = rd_cnt;
      st0 = step_cnt;
      rq0 = req_cnt;
      rxq.push_back(tbl[i].cmd);
      wait_tx(tx0 + NW);
      tick(3);
      chk($sformatf("v%0d_ntx", i), txq.size() - tx0, NW);
      if (txq.size() >= tx0 + NW) begin
`ifdef UART_DBG_ECHO_EN
        chk($sformatf("v%0d_echo", i), txq[tx0], tbl[i].cmd);
`endif
        chk($sformatf("v%0d_resp", i), txq[tx0 + NW - 1], tbl[i].exp);
      end
      chk($sformatf("v%0d_pop", i), rd_cnt - rd0, 1);
      chk($sformatf("v%0d_step", i), step_cnt - st0, tbl[i].stp);
      chk($sformatf("v%0d_run", i), {31'b0, cpu_run}, {31'b0, tbl[i].run});
      chk($sformatf("v%0d_busy", i), {31'b0, busy}, 32'h0);
      if (tbl[i].rd) begin
        chk($sformatf("v%0d_sel", i), {31'b0, dbg_sel}, {31'b0, tbl[i].sel});
        chk($sformatf("v%0d_addr", i), {16'h0, dbg_addr}, {16'h0, tbl[i].addr});
        chk($sformatf("v%0d_req", i), req_cnt - rq0, 1);
        dly = (tbl[i].lat == 0) ? TMO + 2 : tbl[i].lat + 2;
        if (txc.size() >= tx0 + NW)
          chk($sformatf("v%0d_dly", i), txc[tx0 + NW - 1] - req_cyc, dly);
      end else begin
        chk($sformatf("v%0d_req", i), req_cnt - rq0, 0);
        if (txc.size() > tx0)
          chk($sformatf("v%0d_lat", i), txc[tx0] - fall_cyc, 3);
      end
    end

    // TX back-pressure: nothing pushed and no second pop while full
    tx_full = 1'b1;
    tx0 = txq.size();
    rd0 = rd_cnt;
    rxq.push_back(32'h03000000);
    tick(50);
    chk("full_ntx", txq.size() - tx0, 0);
    chk("full_busy", {31'b0, busy}, 32'h1);
    chk("full_pop", rd_cnt - rd0, 1);
    tx_full = 1'b0;
    wait_tx(tx0 + NW);
    tick(3);
    chk("full_rel_ntx", txq.size() - tx0, NW);
    if (txq.size() >= tx0 + NW)
      chk("full_rel_resp", txq[tx0 + NW - 1], 32'hAC000003);

    // reset while waiting on a read; queued RUN survives
    rsp_lat = 0;
    tx0 = txq.size();
    rxq.push_back(32'h01000000);
    wait_tx(tx0 + NW);
    tick(3);
    chk("pre_run", {31'b0, cpu_run}, 32'h1);
    rq0 = req_cnt;
    rxq.push_back(32'h11001234);
    rxq.push_back(32'h01000000);
    k = 0;
    while (req_cnt == rq0 && k < 100) begin
      tick(1);
      k++;
    end
    chk("mid_req_seen", req_cnt - rq0, 1);
    tick(5);
    chk("mid_busy", {31'b0, busy}, 32'h1);
    chk("mid_addr", {16'h0, dbg_addr}, 32'h1234);
    reset = 1'b0;
    #1;
    chk("mid_rst_ctl", {25'b0, rd_uart, wr_uart, cpu_run, cpu_step,
                        dbg_rd_req, dbg_sel, busy}, 32'h0);
    chk("mid_rst_wdata", w_data, 32'h0);
    chk("mid_rst_addr", {16'h0, dbg_addr}, 32'h0);
    tx0 = txq.size();
    tick(2);
    reset = 1'b1;
    wait_tx(tx0 + NW);
    tick(3);
    chk("post_ntx", txq.size() - tx0, NW);
    if (txq.size() >= tx0 + NW)
      chk("post_resp", txq[tx0 + NW - 1], 32'hAC000001);
    chk("post_run", {31'b0, cpu_run}, 32'h1);
    chk("post_rxq", rxq.size(), 0);

    // halt edge clears run on the following cycle
    cpu_halted = 1'b1;
    tick(1);
    chk("halt_clr", {31'b0, cpu_run}, 32'h0);
    cpu_halted = 1'b0;
    tick(2);

    // RUN in DECODE coinciding with a halt edge keeps run set
    tx0 = txq.size();
    rxq.push_back(32'h01000000);
    k = 0;
    while (!rd_uart && k < 20) begin
      tick(1);
      k++;
    end
    chk("race_decode", {31'b0, rd_uart}, 32'h1);
    cpu_halted = 1'b1;
    wait_tx(tx0 + NW);
    tick(2);
    chk("race_run", {31'b0, cpu_run}, 32'h1);
    cpu_halted = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
